mem_stage_lsu: RTL and testbench

//  Parametrised MEM pipeline stage with a real load/store unit. It replaces the fixed single-cycle store stall with a
//  req/gnt/rvalid data-memory handshake of arbitrary latency, and adds in-stage load alignment and sign extension.
//  It also detects misaligned accesses and supports a pipeline flush. Sits between EXE (es_to_ms_valid/ms_allowin)
//  and WB (ms_to_ws_valid/ws_allowin); non-memory ops pass through in one cycle.

---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/lsu_align.sv | 37 +++
 rtl/mem_stage_lsu.sv | 205 ++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and lane helpers for the MEM-stage load/store unit.
// Used by the alignment datapath and the stage FSM.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } lsu_state_e;

  function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] strb;
    case (size)
      SZ_B:    strb = 4'b0001 << off;
      SZ_H:    strb = off[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // size[2] selects zero extension (LBU/LHU)
  function automatic logic [31:0] load_align(input logic [31:0] rdata, input logic [2:0] size,
                                             input logic [1:0] off);
    logic [31:0] bsh;
    logic [31:0] hsh;
    logic [31:0] res;
    bsh = rdata >> {off, 3'b000};
    hsh = rdata >> {off[1], 4'b0000};
    case (size[1:0])
      SZ_B:    res = size[2] ? {24'h000000, bsh[7:0]} : {{24{bsh[7]}}, bsh[7:0]};
      SZ_H:    res = size[2] ? {16'h0000, hsh[15:0]} : {{16{hsh[15]}}, hsh[15:0]};
      default: res = rdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational store lane replication/strobes and load extraction/extension.
// Kept standalone so a future D-cache can share the same lane logic.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        st_size,
  input  logic [1:0]        st_off,
  input  logic [XLEN-1:0]   st_data,
  output logic [XLEN-1:0]   st_wdata,
  output logic [XLEN/8-1:0] st_strb,
  output logic              st_misalign,
  input  logic [2:0]        ld_size,
  input  logic [1:0]        ld_off,
  input  logic [XLEN-1:0]   ld_rdata,
  output logic [XLEN-1:0]   ld_data
);

  // Store data replication onto every lane the access could target
  always_comb begin
    case (st_size[1:0])
      SZ_B:    st_wdata = {4{st_data[7:0]}};
      SZ_H:    st_wdata = {2{st_data[15:0]}};
      default: st_wdata = st_data;
    endcase
  end

  // Strobes, misalignment and load extraction
  always_comb begin
    st_strb     = lane_strb(st_size[1:0], st_off);
    st_misalign = ((st_size[1:0] == SZ_H) && st_off[0]) ||
                  ((st_size[1:0] == SZ_W) && (st_off != 2'b00));
    ld_data     = load_align(ld_rdata, ld_size, ld_off);
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: req/gnt/rvalid data-memory handshake, load alignment,
// misalignment detection, flush handling and an optional rvalid timeout.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 5,
  parameter int MAX_WAIT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              es_to_ms_valid,
  output logic              ms_allowin,
  input  logic [XLEN-1:0]   es_addr,
  input  logic [XLEN-1:0]   es_wdata,
  input  logic [2:0]        es_size,
  input  logic              es_we,
  input  logic              es_re,
  input  logic [TAG_W-1:0]  es_rd,
  input  logic              es_rd_wen,
  input  logic [XLEN-1:0]   es_result,
  input  logic [XLEN-1:0]   es_pc,
  input  logic              flush,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [XLEN/8-1:0] dmem_strb,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              ms_to_ws_valid,
  input  logic              ws_allowin,
  output logic [TAG_W-1:0]  ms_rd,
  output logic              ms_rd_wen,
  output logic [XLEN-1:0]   ms_wdata,
  output logic [XLEN-1:0]   ms_pc,
  output logic              ms_fwd_valid,
  output logic              misalign,
  output logic              bus_err
);

  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  lsu_state_e        state_r;
  lsu_state_e        state_nxt_s;
  logic              accept_s;
  logic              mem_op_s;
  logic              timeout_s;
  logic              ld_take_s;
  logic [XLEN-1:0]   st_wdata_s;
  logic [XLEN/8-1:0] st_strb_s;
  logic              st_mis_s;
  logic [XLEN-1:0]   ld_data_s;
  logic              we_r;
  logic [2:0]        size_r;
  logic [1:0]        off_r;
  logic [XLEN-1:0]   addr_r;
  logic [XLEN-1:0]   wdata_r;
  logic [XLEN/8-1:0] strb_r;
  logic [TAG_W-1:0]  rd_r;
  logic              rd_wen_r;
  logic [XLEN-1:0]   result_r;
  logic [XLEN-1:0]   pc_r;
  logic              misalign_r;
  logic              bus_err_r;
  logic [CNT_W-1:0]  wait_cnt_r;

  lsu_align #(.XLEN(XLEN)) u_align (
    .st_size     (es_size),
    .st_off      (es_addr[1:0]),
    .st_data     (es_wdata),
    .st_wdata    (st_wdata_s),
    .st_strb     (st_strb_s),
    .st_misalign (st_mis_s),
    .ld_size     (size_r),
    .ld_off      (off_r),
    .ld_rdata    (dmem_rdata),
    .ld_data     (ld_data_s)
  );

  // Handshake decode shared by the FSM and the capture registers
  always_comb begin
    ms_allowin = (state_r == ST_IDLE) || ((state_r == ST_DONE) && ws_allowin);
    accept_s   = es_to_ms_valid && ms_allowin && !flush;
    mem_op_s   = es_we || es_re;
    timeout_s  = (MAX_WAIT != 0) && (wait_cnt_r == CNT_W'(MAX_WAIT - 1));
    ld_take_s  = ((state_r == ST_REQ) && dmem_gnt && !we_r && dmem_rvalid) ||
                 ((state_r == ST_WAIT) && dmem_rvalid);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; flush always wins over an accept in the same cycle
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (flush) begin
          state_nxt_s = ST_IDLE;
        end else if (accept_s) begin
          state_nxt_s = (mem_op_s && !st_mis_s) ? ST_REQ : ST_DONE;
        end else if ((state_r == ST_DONE) && ws_allowin) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_REQ: begin
        if (!dmem_gnt) begin
          state_nxt_s = flush ? ST_IDLE : ST_REQ;
        end else if (we_r || dmem_rvalid) begin
          state_nxt_s = flush ? ST_IDLE : ST_DONE;
        end else begin
          state_nxt_s = flush ? ST_DRAIN : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid) begin
          state_nxt_s = flush ? ST_IDLE : ST_DONE;
        end else if (flush || timeout_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        state_nxt_s = dmem_rvalid ? ST_IDLE : ST_DRAIN;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output decode; the fresh load value is forwarded on the rvalid cycle
  always_comb begin
    dmem_req       = (state_r == ST_REQ);
    ms_to_ws_valid = (state_r == ST_DONE);
    ms_fwd_valid   = (state_r == ST_DONE) || ((state_r == ST_WAIT) && dmem_rvalid);
    ms_wdata       = ((state_r == ST_WAIT) && dmem_rvalid) ? ld_data_s : result_r;
  end

  // Instruction capture and load result update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r     <= 1'b0;
      size_r   <= 3'b000;
      off_r    <= 2'b00;
      addr_r   <= {XLEN{1'b0}};
      wdata_r  <= {XLEN{1'b0}};
      strb_r   <= {(XLEN/8){1'b0}};
      rd_r     <= {TAG_W{1'b0}};
      rd_wen_r <= 1'b0;
      result_r <= {XLEN{1'b0}};
      pc_r     <= {XLEN{1'b0}};
    end else if (accept_s) begin
      we_r     <= es_we;
      size_r   <= es_size;
      off_r    <= es_addr[1:0];
      addr_r   <= {es_addr[XLEN-1:2], 2'b00};
      wdata_r  <= st_wdata_s;
      strb_r   <= es_we ? st_strb_s : {(XLEN/8){1'b0}};
      rd_r     <= es_rd;
      rd_wen_r <= es_rd_wen && !(mem_op_s && st_mis_s);
      result_r <= es_result;
      pc_r     <= es_pc;
    end else if (ld_take_s) begin
      result_r <= ld_data_s;
    end else begin
      result_r <= result_r;
    end
  end

  // Event pulses and the rvalid wait counter (cleared whenever not waiting)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_r <= 1'b0;
      bus_err_r  <= 1'b0;
      wait_cnt_r <= {CNT_W{1'b0}};
    end else begin
      misalign_r <= accept_s && mem_op_s && st_mis_s;
      bus_err_r  <= (state_r == ST_WAIT) && !dmem_rvalid && timeout_s;
      wait_cnt_r <= (state_r == ST_WAIT) ? wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
    end
  end

  assign dmem_we    = we_r;
  assign dmem_addr  = addr_r;
  assign dmem_wdata = wdata_r;
  assign dmem_strb  = strb_r;
  assign ms_rd      = rd_r;
  assign ms_rd_wen  = rd_wen_r;
  assign ms_pc      = pc_r;
  assign misalign   = misalign_r;
  assign bus_err    = bus_err_r;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed-vector bench for mem_stage_lsu with hand-computed expectations.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        es_to_ms_valid, ms_allowin;
  logic [31:0] es_addr, es_wdata, es_result, es_pc;
  logic [2:0]  es_size;
  logic        es_we, es_re, es_rd_wen, flush;
  logic [4:0]  es_rd, ms_rd;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_strb;
  logic        ms_to_ws_valid, ws_allowin, ms_rd_wen, ms_fwd_valid, misalign, bus_err;
  logic [31:0] ms_wdata, ms_pc;
  int          n_vec = 0;
  int          n_err = 0;

  mem_stage_lsu #(.XLEN(32), .TAG_W(5), .MAX_WAIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_addr(es_addr), .es_wdata(es_wdata), .es_size(es_size), .es_we(es_we), .es_re(es_re),
    .es_rd(es_rd), .es_rd_wen(es_rd_wen), .es_result(es_result), .es_pc(es_pc), .flush(flush),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_strb(dmem_strb), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin), .ms_rd(ms_rd), .ms_rd_wen(ms_rd_wen),
    .ms_wdata(ms_wdata), .ms_pc(ms_pc), .ms_fwd_valid(ms_fwd_valid), .misalign(misalign),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic we, input logic re, input logic [2:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] result);
    es_to_ms_valid = 1'b1;
    es_we = we; es_re = re; es_size = size; es_addr = addr; es_wdata = wdata;
    es_rd = rd; es_rd_wen = 1'b1; es_result = result; es_pc = addr + 32'h100;
  endtask

  // Load with gnt in REQ's first cycle and rvalid three cycles after gnt
  task automatic run_load(input string tag, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp);
    send(1'b0, 1'b1, size, addr, 32'h0, 5'd4, 32'h0);
    tick(); es_to_ms_valid = 1'b0;
    chk_vec({tag, "_req"}, 32'(dmem_req), 32'd1);
    chk_vec({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
    chk_vec({tag, "_strb"}, 32'(dmem_strb), 32'd0);
    dmem_gnt = 1'b1;
    tick(); dmem_gnt = 1'b0;
    chk_vec({tag, "_wait"}, {30'd0, dmem_req, ms_to_ws_valid}, 32'd0);
    tick(); tick();
    dmem_rvalid = 1'b1; dmem_rdata = rdata; #1;
    chk_vec({tag, "_fwd"}, 32'(ms_fwd_valid), 32'd1);
    chk_vec({tag, "_fwddata"}, ms_wdata, exp);
    tick(); dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    chk_vec({tag, "_valid"}, 32'(ms_to_ws_valid), 32'd1);
    chk_vec({tag, "_data"}, ms_wdata, exp);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; es_to_ms_valid = 1'b0; es_addr = 32'h0; es_wdata = 32'h0; es_result = 32'h0;
    es_pc = 32'h0; es_size = 3'b000; es_we = 1'b0; es_re = 1'b0; es_rd = 5'd0; es_rd_wen = 1'b0;
    flush = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0; ws_allowin = 1'b1;
    tick(); tick();
    chk_vec("rst_outs", {26'd0, ms_to_ws_valid, dmem_req, misalign, bus_err, ms_fwd_valid, ms_rd_wen}, 32'd0);
    chk_vec("rst_allowin", 32'(ms_allowin), 32'd1);
    chk_vec("rst_wdata", ms_wdata, 32'h0);
    chk_vec("rst_strb", 32'(dmem_strb), 32'd0);
    rst_n = 1'b1;
    tick();

    // ALU op passes through in one cycle
    send(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 5'd3, 32'h5);
    tick(); es_to_ms_valid = 1'b0;
    chk_vec("add_valid", 32'(ms_to_ws_valid), 32'd1);
    chk_vec("add_wdata", ms_wdata, 32'h5);
    chk_vec("add_rd", 32'(ms_rd), 32'd3);
    chk_vec("add_noreq", 32'(dmem_req), 32'd0);
    chk_vec("add_fwd", 32'(ms_fwd_valid), 32'd1);
    tick();
    chk_vec("add_gone", 32'(ms_to_ws_valid), 32'd0);

    // SB 0xAB @0x1002, gnt on the third REQ cycle
    send(1'b1, 1'b0, 3'b000, 32'h1002, 32'h0000_00AB, 5'd0, 32'h0);
    tick(); es_to_ms_valid = 1'b0;
    chk_vec("sb_req1", 32'(dmem_req), 32'd1);
    chk_vec("sb_addr", dmem_addr, 32'h1000);
    chk_vec("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
    chk_vec("sb_strb", 32'(dmem_strb), 32'h4);
    chk_vec("sb_we", 32'(dmem_we), 32'd1);
    chk_vec("sb_allowin", 32'(ms_allowin), 32'd0);
    tick();
    chk_vec("sb_req2", 32'(dmem_req), 32'd1);
    tick();
    chk_vec("sb_req3", 32'(dmem_req), 32'd1);
    dmem_gnt = 1'b1;
    tick(); dmem_gnt = 1'b0;
    chk_vec("sb_done", {30'd0, ms_to_ws_valid, dmem_req}, 32'h2);
    tick();

    run_load("lh",  3'b001, 32'h2002, 32'h8001_1234, 32'hFFFF_8001);
    run_load("lhu", 3'b101, 32'h2002, 32'h8001_1234, 32'h0000_8001);
    run_load("lb",  3'b000, 32'h2003, 32'h8001_1234, 32'hFFFF_FF80);
    run_load("lbu", 3'b100, 32'h2001, 32'h8001_1234, 32'h0000_0012);
    run_load("lw",  3'b010, 32'h2000, 32'h8001_1234, 32'h8001_1234);

    // Misaligned LW
    send(1'b0, 1'b1, 3'b010, 32'h3001, 32'h0, 5'd5, 32'h0);
    tick(); es_to_ms_valid = 1'b0;
    chk_vec("mis_pulse", 32'(misalign), 32'd1);
    chk_vec("mis_noreq", 32'(dmem_req), 32'd0);
    chk_vec("mis_wen", 32'(ms_rd_wen), 32'd0);
    chk_vec("mis_valid", 32'(ms_to_ws_valid), 32'd1);
    tick();
    chk_vec("mis_end", {30'd0, misalign, dmem_req}, 32'd0);

    // Flush in WAIT -> DRAIN, rvalid discarded
    send(1'b0, 1'b1, 3'b010, 32'h4000, 32'h0, 5'd6, 32'h0);
    tick(); es_to_ms_valid = 1'b0; dmem_gnt = 1'b1;
    tick(); dmem_gnt = 1'b0; flush = 1'b1;
    tick(); flush = 1'b0;
    chk_vec("drn_allowin", 32'(ms_allowin), 32'd0);
    chk_vec("drn_valid", 32'(ms_to_ws_valid), 32'd0);
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF; #1;
    chk_vec("drn_nofwd", 32'(ms_fwd_valid), 32'd0);
    tick(); dmem_rvalid = 1'b0;
    chk_vec("drn_idle", {30'd0, ms_allowin, ms_to_ws_valid}, 32'h2);
    send(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 5'd7, 32'h77);
    tick(); es_to_ms_valid = 1'b0;
    chk_vec("drn_next", ms_wdata, 32'h77);
    chk_vec("drn_next_v", 32'(ms_to_ws_valid), 32'd1);
    tick();

    // Flush in REQ without gnt withdraws the request
    send(1'b0, 1'b1, 3'b010, 32'h6000, 32'h0, 5'd8, 32'h0);
    tick(); es_to_ms_valid = 1'b0; flush = 1'b1;
    tick(); flush = 1'b0;
    chk_vec("fq_withdraw", {29'd0, dmem_req, ms_allowin, ms_to_ws_valid}, 32'h2);

    // Flush in DONE beats a same-cycle accept
    send(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 5'd1, 32'h99);
    tick();
    send(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 5'd2, 32'hAA); flush = 1'b1;
    tick(); flush = 1'b0; es_to_ms_valid = 1'b0;
    chk_vec("fd_drop", 32'(ms_to_ws_valid), 32'd0);
    chk_vec("fd_allowin", 32'(ms_allowin), 32'd1);

    // WB backpressure: bundle holds for 4 cycles, then back-to-back accept
    send(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 5'd9, 32'h1234); ws_allowin = 1'b0;
    tick();
    send(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 5'd10, 32'h5555);
    for (int i = 0; i < 4; i++) begin
      chk_vec("stall_bundle", {ms_wdata[23:0], 3'd0, ms_rd}, {24'h001234, 3'd0, 5'd9});
      chk_vec("stall_ctl", {30'd0, ms_to_ws_valid, ms_allowin}, 32'h2);
      tick();
    end
    ws_allowin = 1'b1; #1;
    chk_vec("stall_release", 32'(ms_allowin), 32'd1);
    tick(); es_to_ms_valid = 1'b0;
    chk_vec("b2b_data", ms_wdata, 32'h5555);
    chk_vec("b2b_rd", 32'(ms_rd), 32'd10);
    tick();

    // MAX_WAIT=8 timeout with no rvalid
    send(1'b0, 1'b1, 3'b010, 32'h5000, 32'h0, 5'd11, 32'h0);
    tick(); es_to_ms_valid = 1'b0; dmem_gnt = 1'b1;
    tick(); dmem_gnt = 1'b0;
    for (int k = 1; k < 8; k++) begin
      tick();
      chk_vec("to_quiet", 32'(bus_err), 32'd0);
    end
    tick();
    chk_vec("to_buserr", 32'(bus_err), 32'd1);
    chk_vec("to_drop", {30'd0, ms_to_ws_valid, ms_allowin}, 32'd0);
    tick();
    chk_vec("to_pulse", 32'(bus_err), 32'd0);
    dmem_rvalid = 1'b1;
    tick(); dmem_rvalid = 1'b0;
    chk_vec("to_absorb", {30'd0, ms_allowin, ms_to_ws_valid}, 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
